// File: rtl/stream_arb_pkg.sv
// Shared definitions for the 2:1 round-robin stream arbiter.
//   SEL_A / SEL_B : source index encoding carried on out_sel and the round-robin pointer
//   DEF_WIDTH     : default payload width
//   STAT_W/MAX    : grant statistics counter width and saturation value
package stream_arb_pkg;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int unsigned DEF_WIDTH = 8;

  localparam int unsigned STAT_W   = 16;
  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Saturating increment for the grant statistics counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == STAT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/stream_arb_2x1_if.sv
// Stream bundle for stream_arb_2x1: two valid/ready producer streams (a, b) and one
// registered output stream (out) with its source tag out_sel.
//   modport slave  : arbiter view (consumes a/b, drives out)
//   modport master : environment view (drives a/b producers and out_ready)
interface stream_arb_2x1_if #(
  parameter int unsigned WIDTH = stream_arb_pkg::DEF_WIDTH
);

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_sel;
  logic             out_ready;

  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, out_sel
  );

  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/rr_grant2.sv
// Combinational two-requester round-robin grant.
//   req[1:0] : request vector, bit 0 = A, bit 1 = B
//   last_sel : index granted most recently; on contention the other one wins
//   en       : grant enable; no grant when low
//   gnt[1:0] : one-hot grant
//   gnt_idx  : index of the granted requester (SEL_A when no grant)
module rr_grant2
  import stream_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_sel,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  always_comb begin
    gnt     = 2'b00;
    gnt_idx = SEL_A;
    if (en) begin
      unique case (req)
        2'b01: begin
          gnt     = 2'b01;
          gnt_idx = SEL_A;
        end
        2'b10: begin
          gnt     = 2'b10;
          gnt_idx = SEL_B;
        end
        2'b11: begin
          if (last_sel == SEL_B) begin
            gnt     = 2'b01;
            gnt_idx = SEL_A;
          end else begin
            gnt     = 2'b10;
            gnt_idx = SEL_B;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/stream_arb_2x1.sv
// Registered round-robin 2:1 stream arbiter. Picks a winner between streams A and B,
// captures its word into a one-entry output register and tags it with out_sel.
//   clk, rst : clock and synchronous active-high reset
//   bus      : stream_arb_2x1_if.slave (a_*, b_* inputs, out_* output stream)
// Optional build macro ARB_STATS_EN adds grant_cnt_a / grant_cnt_b saturating
// handshake counters (16 bit).
module stream_arb_2x1
  import stream_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  stream_arb_2x1_if.slave       bus
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]     grant_cnt_a,
  output logic [STAT_W-1:0]     grant_cnt_b
`endif
);

  logic             load;
  logic [1:0]       gnt;
  logic             gnt_idx;

  logic             out_valid_q, out_valid_d;
  logic             out_sel_q, out_sel_d;
  logic             last_sel_q, last_sel_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  // Register can accept a word when empty or draining this cycle.
  assign load = ~out_valid_q | bus.out_ready;

  // Gating with rst keeps both readys low while reset is held.
  rr_grant2 u_grant (
    .req      ({bus.b_valid, bus.a_valid}),
    .last_sel (last_sel_q),
    .en       (load & ~rst),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign bus.a_ready   = gnt[0];
  assign bus.b_ready   = gnt[1];
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

  always_comb begin
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    last_sel_d  = last_sel_q;
    out_data_d  = out_data_q;
    if (load) begin
      if (|gnt) begin
        out_valid_d = 1'b1;
        out_sel_d   = gnt_idx;
        last_sel_d  = gnt_idx;
        out_data_d  = (gnt_idx == SEL_B) ? bus.b_data : bus.a_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sel_q   <= SEL_A;
      last_sel_q  <= SEL_B;  // A wins the first contested cycle
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      last_sel_q  <= last_sel_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (gnt[0]) cnt_a_q <= sat_inc(cnt_a_q);
      if (gnt[1]) cnt_b_q <= sat_inc(cnt_b_q);
    end
  end

  assign grant_cnt_a = cnt_a_q;
  assign grant_cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_stream_arb_2x1.sv
// Self-checking bench for stream_arb_2x1: directed scenarios followed by a randomized
// phase, all checked against a behavioural model and an output scoreboard.
module tb_stream_arb_2x1;
  import stream_arb_pkg::*;

  localparam int unsigned W = 8;

  typedef struct {
    logic         sel;
    logic [W-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_arb_2x1_if #(.WIDTH(W)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] grant_cnt_a, grant_cnt_b;
`endif

  stream_arb_2x1 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef ARB_STATS_EN
    ,
    .grant_cnt_a (grant_cnt_a),
    .grant_cnt_b (grant_cnt_b)
`endif
  );

  int   n_pass  = 0;
  int   n_total = 0;
  bit   started = 1'b0;

  // Reference model state
  exp_t expq[$];
  bit   m_full = 1'b0;
  bit   m_last = 1'b1;    // 1 = B granted last, so A is favoured
  int   m_cnt_a = 0;
  int   m_cnt_b = 0;
  bit   a_hs, b_hs;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // One clock: compare readys/valid to the model at negedge, advance the model,
  // then return 1 time unit after the following rising edge.
  task automatic cycle();
    int   g;
    bit   ld;
    exp_t ne;
    @(negedge clk);
    check("out_valid", {31'd0, bus.out_valid}, {31'd0, m_full});
    if (rst) begin
      check("a_ready_rst", {31'd0, bus.a_ready}, 32'd0);
      check("b_ready_rst", {31'd0, bus.b_ready}, 32'd0);
      m_full  = 1'b0;
      m_last  = 1'b1;
      m_cnt_a = 0;
      m_cnt_b = 0;
      expq.delete();
    end else begin
      ld = !m_full || bus.out_ready;
      g  = -1;
      if (ld) begin
        if (bus.a_valid && bus.b_valid) g = m_last ? 0 : 1;
        else if (bus.a_valid)           g = 0;
        else if (bus.b_valid)           g = 1;
      end
      check("a_ready", {31'd0, bus.a_ready}, (g == 0) ? 32'd1 : 32'd0);
      check("b_ready", {31'd0, bus.b_ready}, (g == 1) ? 32'd1 : 32'd0);
      if (g >= 0) begin
        ne.sel  = (g == 1);
        ne.data = (g == 1) ? bus.b_data : bus.a_data;
        expq.push_back(ne);
        m_last = (g == 1);
        m_full = 1'b1;
        if (g == 0 && m_cnt_a < 65535) m_cnt_a++;
        if (g == 1 && m_cnt_b < 65535) m_cnt_b++;
      end else if (ld) begin
        m_full = 1'b0;
      end
    end
    a_hs = bus.a_valid && bus.a_ready;
    b_hs = bus.b_valid && bus.b_ready;
    @(posedge clk);
    #1;
  endtask

  // Let any pending input words go through and empty the output register.
  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (a_hs) bus.a_valid = 1'b0;
      if (b_hs) bus.b_valid = 1'b0;
    end
  endtask

  // Scoreboard monitor: pops one expected word per output handshake.
  exp_t e;
  always @(negedge clk) begin
    if (started && !rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (expq.size() == 0) begin
        n_total++;
        $display("FAIL out_word: unexpected word %0h, expected none", bus.out_data);
      end else begin
        e = expq.pop_front();
        check("out_data", {24'd0, bus.out_data}, {24'd0, e.data});
        check("out_sel", {31'd0, bus.out_sel}, {31'd0, e.sel});
      end
    end
  end

  logic [W-1:0] seq [6];

  initial begin
    bus.a_valid = 1'b0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_data = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    started = 1'b1;

    // Reset held for two checked cycles, then idle
    cycle(); cycle();
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_out_sel", {31'd0, bus.out_sel}, 32'd0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("idle_out_data", {24'd0, bus.out_data}, 32'd0);
    end

    // Single source A
    bus.a_valid = 1'b1; bus.a_data = 8'h3C;
    cycle();
    bus.a_valid = 1'b0;
    check("single_valid", {31'd0, bus.out_valid}, 32'd1);
    check("single_data", {24'd0, bus.out_data}, 32'h3C);
    check("single_sel", {31'd0, bus.out_sel}, 32'd0);
    cycle();

    // One B word so that A is favoured for the contention run
    bus.b_valid = 1'b1; bus.b_data = 8'h11;
    cycle();
    bus.b_valid = 1'b0;
    cycle();

    // Contention fairness
    seq[0] = 8'hA0; seq[1] = 8'hB0; seq[2] = 8'hA1;
    seq[3] = 8'hB1; seq[4] = 8'hA2; seq[5] = 8'hB2;
    bus.a_valid = 1'b1; bus.a_data = 8'hA0;
    bus.b_valid = 1'b1; bus.b_data = 8'hB0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("fair_data", {24'd0, bus.out_data}, {24'd0, seq[i]});
      check("fair_sel", {31'd0, bus.out_sel}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (a_hs) bus.a_data = bus.a_data + 8'd1;
      if (b_hs) bus.b_data = bus.b_data + 8'd1;
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    drain();

    // Backpressure holding 8'h55
    bus.a_valid = 1'b1; bus.a_data = 8'h55;
    bus.out_ready = 1'b0;
    cycle();
    bus.a_data = 8'h56;
    bus.b_valid = 1'b1; bus.b_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_data", {24'd0, bus.out_data}, 32'h55);
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    cycle();
    check("bp_refill", {24'd0, bus.out_data}, 32'h66);
    if (b_hs) bus.b_valid = 1'b0;
    drain();

    // Reset while holding B's 8'h77
    bus.b_valid = 1'b1; bus.b_data = 8'h77;
    bus.out_ready = 1'b0;
    cycle();
    bus.b_valid = 1'b0;
    check("pre_rst_data", {24'd0, bus.out_data}, 32'h77);
    check("pre_rst_sel", {31'd0, bus.out_sel}, 32'd1);
    bus.a_valid = 1'b1; bus.a_data = 8'h12;
    bus.b_valid = 1'b1; bus.b_data = 8'h34;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    cycle();
    check("post_rst_sel", {31'd0, bus.out_sel}, 32'd0);
    check("post_rst_data", {24'd0, bus.out_data}, 32'h12);
    if (a_hs) bus.a_valid = 1'b0;
    drain();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (!bus.a_valid || a_hs) begin
        bus.a_valid = ($urandom_range(0, 99) < 60);
        bus.a_data  = 8'($urandom);
      end
      if (!bus.b_valid || b_hs) begin
        bus.b_valid = ($urandom_range(0, 99) < 60);
        bus.b_data  = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 99) < 70);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    drain();
    check("scoreboard_empty", expq.size(), 32'd0);
`ifdef ARB_STATS_EN
    check("rand_cnt_a", {16'd0, grant_cnt_a}, m_cnt_a);
    check("rand_cnt_b", {16'd0, grant_cnt_b}, m_cnt_b);

    // Five A and three B handshakes after reset
    rst = 1'b1; cycle(); cycle(); rst = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.a_valid = 1'b1; bus.a_data = 8'(i);
      cycle();
      bus.a_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      bus.b_valid = 1'b1; bus.b_data = 8'(i + 8);
      cycle();
      bus.b_valid = 1'b0;
    end
    cycle();
    check("stat_cnt_a", {16'd0, grant_cnt_a}, 32'd5);
    check("stat_cnt_b", {16'd0, grant_cnt_b}, 32'd3);

    // Saturation of A's counter
    bus.a_valid = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      cycle();
      if (a_hs) bus.a_data = bus.a_data + 8'd1;
    end
    bus.a_valid = 1'b0;
    cycle();
    check("stat_sat_a", {16'd0, grant_cnt_a}, 32'hFFFF);
    check("stat_b_hold", {16'd0, grant_cnt_b}, 32'd3);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
